// File: rtl/ccd_frame_gen.sv
// Synthetic CCD source: programmable FVAL/LVAL timing with four test patterns on the pixel clock.
// Optional LFSR noise on the low data bits when CCD_FRAME_GEN_NOISE_EN is defined.
module ccd_frame_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 32
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic [1:0]  iPATTERN,
    input  logic [11:0] iLEVEL,
    output logic [11:0] oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [15:0] oFrame_Cont,
    output logic        oBusy
);

    typedef enum logic [2:0] {IDLE, FRONT, LINE, HGAP, VBLANK} state_t;

    localparam logic [15:0] X_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);
    localparam logic [15:0] BX_LO   = 16'(H_ACTIVE / 4);
    localparam logic [15:0] BX_HI   = 16'((3 * H_ACTIVE) / 4);
    localparam logic [15:0] BY_LO   = 16'(V_ACTIVE / 4);
    localparam logic [15:0] BY_HI   = 16'((3 * V_ACTIVE) / 4);

    state_t      state;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] cnt;
    logic        stop_pend;
    logic [1:0]  pat_q;
    logic [11:0] level_q;
`ifdef CCD_FRAME_GEN_NOISE_EN
    logic [15:0] lfsr;
`endif

    // Data is registered, so each pixel is computed one cycle ahead from the column about to be shown.
    function automatic logic [11:0] pixel(input logic [15:0] px, input logic [15:0] py);
        logic [11:0] v;
        v = '0;
        case (pat_q)
            2'd0:    v = px[11:0] + py[11:0];
            2'd1:    v = (px[3] ^ py[3]) ? 12'hFFF : 12'h000;
            2'd2:    v = (px >= BX_LO && px < BX_HI && py >= BY_LO && py < BY_HI) ? '1 : '0;
            default: v = level_q;
        endcase
`ifdef CCD_FRAME_GEN_NOISE_EN
        if (pat_q != 2'd2)
            v[3:0] = v[3:0] ^ lfsr[3:0];
`endif
        return v;
    endfunction

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            cnt         <= '0;
            stop_pend   <= 1'b0;
            pat_q       <= '0;
            level_q     <= '0;
            oDATA       <= '0;
            oFVAL       <= 1'b0;
            oLVAL       <= 1'b0;
            oFrame_Cont <= '0;
            oBusy       <= 1'b0;
`ifdef CCD_FRAME_GEN_NOISE_EN
            lfsr        <= 16'hACE1;
`endif
        end else begin
`ifdef CCD_FRAME_GEN_NOISE_EN
            if (state == LINE)
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
            if (state != IDLE && iSTOP)
                stop_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (iSTART && !iSTOP) begin
                        state   <= FRONT;
                        oFVAL   <= 1'b1;
                        oBusy   <= 1'b1;
                        cnt     <= '0;
                        y       <= '0;
                        pat_q   <= iPATTERN;
                        level_q <= iLEVEL;
                    end
                end
                FRONT: begin
                    if (cnt == HB_LAST) begin
                        state <= LINE;
                        oLVAL <= 1'b1;
                        x     <= '0;
                        oDATA <= pixel(16'd0, y);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                LINE: begin
                    if (x == X_LAST) begin
                        state <= HGAP;
                        oLVAL <= 1'b0;
                        oDATA <= '0;
                        cnt   <= '0;
                    end else begin
                        x     <= x + 16'd1;
                        oDATA <= pixel(x + 16'd1, y);
                    end
                end
                HGAP: begin
                    if (cnt == HB_LAST) begin
                        if (y == Y_LAST) begin
                            state       <= VBLANK;
                            oFVAL       <= 1'b0;
                            cnt         <= '0;
                            oFrame_Cont <= oFrame_Cont + 16'd1;
                        end else begin
                            state <= LINE;
                            oLVAL <= 1'b1;
                            x     <= '0;
                            y     <= y + 16'd1;
                            oDATA <= pixel(16'd0, y + 16'd1);
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                VBLANK: begin
                    if (cnt == VB_LAST) begin
                        // A stop arriving on the very last blanking cycle still ends the run here.
                        if (stop_pend || iSTOP) begin
                            state     <= IDLE;
                            oBusy     <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            state   <= FRONT;
                            oFVAL   <= 1'b1;
                            cnt     <= '0;
                            y       <= '0;
                            pat_q   <= iPATTERN;
                            level_q <= iLEVEL;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccd_frame_gen.sv
// Randomized self-checking bench for ccd_frame_gen against a frame-level arithmetic model.
module tb_ccd_frame_gen;

    localparam int HA     = 8;
    localparam int VA     = 4;
    localparam int HB     = 3;
    localparam int VB     = 5;
    localparam int FV_LEN = HB + VA * (HA + HB);
    localparam int PERIOD = FV_LEN + VB;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iSTART = 1'b0;
    logic        iSTOP = 1'b0;
    logic [1:0]  iPATTERN = 2'd0;
    logic [11:0] iLEVEL = 12'd0;
    logic [11:0] oDATA;
    logic        oFVAL;
    logic        oLVAL;
    logic [15:0] oFrame_Cont;
    logic        oBusy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_cnt = 16'd0;

    ccd_frame_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP),
        .iPATTERN(iPATTERN), .iLEVEL(iLEVEL), .oDATA(oDATA), .oFVAL(oFVAL),
        .oLVAL(oLVAL), .oFrame_Cont(oFrame_Cont), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] exp_pixel(input int pat, input logic [11:0] lvl, input int x, input int y);
        case (pat)
            0:       return 12'((x + y) % 4096);
            1:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
            2:       return (x >= HA / 4 && x < (3 * HA) / 4 && y >= VA / 4 && y < (3 * VA) / 4) ? 12'hFFF : 12'h000;
            default: return lvl;
        endcase
    endfunction

    // Walks one whole frame period from its first FVAL-high cycle, checking every output each cycle.
    task automatic run_frame(input int pat, input logic [11:0] lvl, input int stop_at,
                             input int chg_at, input logic [1:0] chg_pat, input logic [11:0] chg_lvl);
        logic        efval, elval, ebusy;
        logic [11:0] edata, emask;
        int          j, pos, row;
`ifdef CCD_FRAME_GEN_NOISE_EN
        emask = (pat == 2) ? 12'hFFF : 12'hFF0;
`else
        emask = 12'hFFF;
`endif
        for (int k = 0; k < PERIOD; k++) begin
            efval = (k < FV_LEN);
            elval = 1'b0;
            edata = 12'd0;
            ebusy = 1'b1;
            if (k >= HB && k < FV_LEN) begin
                j   = k - HB;
                pos = j % (HA + HB);
                row = j / (HA + HB);
                if (pos < HA) begin
                    elval = 1'b1;
                    edata = exp_pixel(pat, lvl, pos, row);
                end
            end
            if (k == FV_LEN)
                exp_cnt = exp_cnt + 16'd1;
            vectors++;
            if (oFVAL !== efval) begin
                miscompares++;
                $display("FAIL fval k=%0d got %b exp %b", k, oFVAL, efval);
            end
            vectors++;
            if (oLVAL !== elval) begin
                miscompares++;
                $display("FAIL lval k=%0d got %b exp %b", k, oLVAL, elval);
            end
            vectors++;
            if ((oDATA & emask) !== (edata & emask)) begin
                miscompares++;
                $display("FAIL data k=%0d pat=%0d got %h exp %h", k, pat, oDATA, edata);
            end
            vectors++;
            if (oBusy !== ebusy) begin
                miscompares++;
                $display("FAIL busy k=%0d got %b exp %b", k, oBusy, ebusy);
            end
            vectors++;
            if (oFrame_Cont !== exp_cnt) begin
                miscompares++;
                $display("FAIL frame_cont k=%0d got %0d exp %0d", k, oFrame_Cont, exp_cnt);
            end
            iSTOP = (k == stop_at);
            if (k == chg_at) begin
                iPATTERN = chg_pat;
                iLEVEL   = chg_lvl;
            end
            @(posedge iCLK); #1;
        end
        iSTOP = 1'b0;
    endtask

    task automatic check_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (oFVAL !== 1'b0 || oLVAL !== 1'b0 || oBusy !== 1'b0 || oDATA !== 12'd0) begin
                miscompares++;
                $display("FAIL %s_idle i=%0d got fval=%b lval=%b busy=%b data=%h exp all 0", tag, i, oFVAL, oLVAL, oBusy, oDATA);
            end
            vectors++;
            if (oFrame_Cont !== exp_cnt) begin
                miscompares++;
                $display("FAIL %s_idle_cnt i=%0d got %0d exp %0d", tag, i, oFrame_Cont, exp_cnt);
            end
            @(posedge iCLK); #1;
        end
    endtask

    task automatic start_frame();
        iSTART = 1'b1;
        @(posedge iCLK); #1;
        iSTART = 1'b0;
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        repeat (2) @(posedge iCLK);
        #1;
        exp_cnt = 16'd0;
        vectors++;
        if (oFVAL !== 1'b0 || oLVAL !== 1'b0 || oBusy !== 1'b0 || oDATA !== 12'd0 || oFrame_Cont !== 16'd0) begin
            miscompares++;
            $display("FAIL reset got fval=%b lval=%b busy=%b data=%h cnt=%0d exp all 0", oFVAL, oLVAL, oBusy, oDATA, oFrame_Cont);
        end
        iRST = 1'b0;
        @(posedge iCLK); #1;
        check_idle(2, "post_reset");
    endtask

    task automatic test_start_stop_idle();
        iSTART = 1'b1;
        iSTOP  = 1'b1;
        check_idle(4, "start_and_stop");
        iSTART = 1'b0;
        iSTOP  = 1'b0;
        check_idle(1, "release");
    endtask

    task automatic test_ramp();
        iPATTERN = 2'd0;
        iLEVEL   = 12'($urandom);
        start_frame();
        run_frame(0, 12'd0, -1, -1, 2'd0, 12'd0);
        run_frame(0, 12'd0, 20, -1, 2'd0, 12'd0);
        check_idle(8, "ramp_stop");
    endtask

    task automatic test_box();
        iPATTERN = 2'd2;
        start_frame();
        run_frame(2, 12'd0, 30, -1, 2'd0, 12'd0);
        check_idle(6, "box_stop");
    endtask

    task automatic test_pattern_latch();
        logic [11:0] nl;
        nl = 12'($urandom);
        iPATTERN = 2'd3;
        iLEVEL   = 12'h5A5;
        start_frame();
        run_frame(3, 12'h5A5, -1, 15, 2'd1, nl);
        run_frame(1, nl, 10, -1, 2'd1, 12'd0);
        check_idle(6, "latch_stop");
    endtask

    task automatic test_async_reset();
        iPATTERN = 2'($urandom_range(0, 3));
        start_frame();
        repeat (5) begin
            @(posedge iCLK); #1;
        end
        vectors++;
        if (oLVAL !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_lval got %b exp 1", oLVAL);
        end
        #2 iRST = 1'b1;
        #1;
        exp_cnt = 16'd0;
        vectors++;
        if (oFVAL !== 1'b0 || oLVAL !== 1'b0 || oDATA !== 12'd0 || oBusy !== 1'b0 || oFrame_Cont !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset got fval=%b lval=%b busy=%b data=%h cnt=%0d exp all 0", oFVAL, oLVAL, oBusy, oDATA, oFrame_Cont);
        end
        #2 iRST = 1'b0;
        @(posedge iCLK); #1;
        check_idle(2, "after_async");
        iPATTERN = 2'd0;
        start_frame();
        run_frame(0, 12'd0, 3, -1, 2'd0, 12'd0);
        check_idle(6, "after_async_stop");
    endtask

    task automatic test_back_to_back();
        int          cur, nxt, chg;
        logic [11:0] lcur, lnxt;
        cur  = int'($urandom_range(0, 3));
        lcur = 12'($urandom);
        iPATTERN = 2'(cur);
        iLEVEL   = lcur;
        start_frame();
        for (int f = 0; f < 4; f++) begin
            nxt  = int'($urandom_range(0, 3));
            lnxt = 12'($urandom);
            chg  = int'($urandom_range(0, FV_LEN - 1));
            run_frame(cur, lcur, (f == 3) ? int'($urandom_range(0, FV_LEN - 1)) : -1, chg, 2'(nxt), lnxt);
            cur  = nxt;
            lcur = lnxt;
        end
        check_idle(6, "b2b_stop");
    endtask

    initial begin
        #1;
        test_reset();
        test_start_stop_idle();
        test_ramp();
        test_box();
        test_pattern_latch();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ccd_frame_gen.md
# ccd_frame_gen

Synthetic camera-side source that drives the same FVAL/LVAL/12-bit DATA interface the CCD capture path consumes. It lets the capture → black/white → ROI → SDRAM chain run and be verified without a D5M module attached. The block generates programmable frame timing and one of four test patterns, and sits in place of the GPIO camera pins on the pixel clock domain.

## Interface
- H_ACTIVE, 640: pixels per line (LVAL high cycles); ≥2
- V_ACTIVE, 480: lines per frame; ≥2
- H_BLANK, 16: LVAL-low cycles before the first line and after every line; ≥1
- V_BLANK, 32: FVAL-low cycles between frames; ≥1
- iCLK  in  1  pixel clock; all outputs registered on its rising edge
- iRST  in  1  asynchronous, active-high reset
- iSTART  in  1  level/pulse; starts continuous frame generation when idle
- iSTOP  in  1  level/pulse; requests stop at the next frame boundary
- iPATTERN  in  2  0 ramp, 1 checkerboard, 2 centre box, 3 constant
- iLEVEL  in  12  pixel value for pattern 3
- oDATA  out  12  pixel data; 0 whenever oLVAL=0
- oFVAL  out  1  frame valid
- oLVAL  out  1  line valid (only while oFVAL=1)
- oFrame_Cont  out  16  completed-frame count
- oBusy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, FRONT, LINE, HGAP, VBLANK.
- IDLE: all outputs 0 except oFrame_Cont. If iSTART=1 and iSTOP=0, go to FRONT. Stop wins over start when both are high in the same cycle.
- FRONT: oFVAL=1, oLVAL=0 for H_BLANK cycles, then LINE. iPATTERN and iLEVEL are latched on entry and used for the whole frame.
- LINE: oFVAL=1, oLVAL=1 for H_ACTIVE cycles. Column x counts 0..H_ACTIVE-1; row y is held. Then HGAP.
- HGAP: oFVAL=1, oLVAL=0 for H_BLANK cycles. If y=V_ACTIVE-1, go to VBLANK; otherwise increment y and go to LINE.
- VBLANK: oFVAL=0 for V_BLANK cycles, then go to IDLE if a stop is pending, else FRONT. oFrame_Cont increments on entry to VBLANK and wraps from 16'hFFFF to 0.
- Stop request: iSTOP=1 in any non-IDLE state sets a sticky pending flag. The flag clears on entering IDLE. The current frame always completes. iSTOP in IDLE is ignored.
- iSTART while busy is ignored.
- Patterns (x, y are 16-bit counters; the result is truncated to 12 bits):
  - 0: (x + y)[11:0]
  - 1: (x[3] ^ y[3]) ? 12'hFFF : 12'h000
  - 2: 12'hFFF when H_ACTIVE/4 ≤ x < 3·H_ACTIVE/4 and V_ACTIVE/4 ≤ y < 3·V_ACTIVE/4, else 0
  - 3: latched iLEVEL
- Reset, asynchronous at any point, including mid-line: state IDLE; oDATA=0, oFVAL=0, oLVAL=0, oBusy=0, oFrame_Cont=0; stop flag, x and y cleared.

## Timing
- iSTART sampled high at edge t: oFVAL=1 and oBusy=1 from edge t+1.
- First oLVAL rising edge occurs H_BLANK cycles after oFVAL rises.
- oDATA is valid in the same cycle as oLVAL. There is no pipeline offset between oLVAL and oDATA.
- FVAL-high length per frame: H_BLANK + V_ACTIVE·(H_ACTIVE + H_BLANK) cycles.
- Frame period: that FVAL-high length + V_BLANK cycles.
- oLVAL never rises in the same cycle oFVAL rises, and oFVAL never falls while oLVAL=1.
- oFrame_Cont updates in the cycle oFVAL first reads 0.
- After a stop, oBusy falls together with the transition to IDLE, i.e. V_BLANK cycles after oFVAL falls.

## Configuration
- CCD_FRAME_GEN_NOISE_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every LINE cycle. Its low 4 bits are XORed into oDATA[3:0] for patterns 0, 1 and 3. Pattern 2 stays noise-free so ROI checks remain exact.
- Not defined: no LFSR is built and patterns are exact.

## Test plan
(Parameters H_ACTIVE=8, V_ACTIVE=4, H_BLANK=3, V_BLANK=5, macro undefined unless stated.)
- Reset then iSTART pulse → oFVAL high for 47 cycles, 4 LVAL bursts of 8 cycles each separated by 3-cycle gaps, oFVAL low for 5 cycles; oFrame_Cont=1 at the first FVAL-low cycle.
- Pattern 0, line y=2 → oDATA sequence 2,3,…,9; oDATA=0 during every gap.
- Pattern 2 → 12'hFFF only at x=2..5 on y=1..2; all other active pixels are 0.
- iSTOP pulsed mid-line of frame 1 → frame 1 completes unchanged, oBusy falls 5 cycles after oFVAL falls, no second FVAL; iSTART and iSTOP high together in IDLE → stays IDLE.
- iRST asserted during LINE → same cycle (asynchronous) oFVAL=oLVAL=oDATA=0, oFrame_Cont=0; a subsequent iSTART produces a clean 47-cycle frame.
- iPATTERN changed 3→1 mid-frame with iLEVEL=12'h5A5 → the current frame stays 12'h5A5 throughout; the next frame is the checkerboard. With CCD_FRAME_GEN_NOISE_EN defined, oDATA[11:4] of that frame still equals 12'h5A5[11:4].
